// File: rtl/key_pkg.sv
// key_pkg: shared FSM state type, 24 MHz default timing constants and counter-width helper.
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;
  localparam int CLK_HZ           = 24_000_000;
  localparam int DEF_DEBOUNCE_CYC = CLK_HZ / 100;
  localparam int DEF_LONG_CYC     = CLK_HZ * 2;
  localparam int DEF_REPEAT_CYC   = CLK_HZ / 5;
  function automatic int cw(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction
endpackage

// File: rtl/key_chan.sv
// key_chan: one key channel (2-flop synchronizer, debounce FSM, long-press and optional KEY_AUTOREPEAT_EN repeat timer).
module key_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic rpt_pulse
);
  localparam int DW = cw(DEBOUNCE_CYC);
  localparam int LW = cw(LONG_CYC);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] L_PRE  = LW'(LONG_CYC - 2);
  if (DEBOUNCE_CYC < 1 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 1) begin : g_bad_cfg
    $error("key_chan: invalid timing parameters");
  end
  logic [1:0] sync;
  key_state_t state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [LW-1:0] lcnt, lcnt_nx;
  logic pressed, held, p, r, l;
  assign pressed = ~sync[1];
  assign held = state == HELD || state == RELEASE_WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      state <= IDLE;
      dcnt  <= '0;
      lcnt  <= '0;
    end else begin
      sync  <= {sync[0], key_n};
      state <= state_nx;
      dcnt  <= dcnt_nx;
      lcnt  <= lcnt_nx;
    end
  end
  // Long count runs through RELEASE_WAIT so a bounce never delays the long-press event.
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    lcnt_nx  = held ? ((lcnt == L_LAST) ? lcnt : lcnt + 1'b1) : lcnt;
    p        = 1'b0;
    r        = 1'b0;
    case (state)
      IDLE: begin
        state_nx = pressed ? PRESS_WAIT : IDLE;
        dcnt_nx  = '0;
      end
      PRESS_WAIT: begin
        state_nx = !pressed ? IDLE : (dcnt == D_LAST) ? HELD : PRESS_WAIT;
        p        = pressed && dcnt == D_LAST;
        dcnt_nx  = dcnt + 1'b1;
        lcnt_nx  = '0;
      end
      HELD: begin
        state_nx = pressed ? HELD : RELEASE_WAIT;
        dcnt_nx  = '0;
      end
      RELEASE_WAIT: begin
        state_nx = pressed ? HELD : (dcnt == D_LAST) ? IDLE : RELEASE_WAIT;
        r        = !pressed && dcnt == D_LAST;
        dcnt_nx  = dcnt + 1'b1;
      end
    endcase
  end
  assign l             = held && lcnt == L_PRE && !r;
  assign key_level     = held && !rst;
  assign press_pulse   = p && !rst;
  assign release_pulse = r && !rst;
  assign long_pulse    = l && !rst;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cw(REPEAT_CYC);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rcnt;
  logic rpt, rpt_run;
  assign rpt_run = state == HELD && lcnt == L_LAST;
  assign rpt     = rpt_run && rcnt == R_LAST;
  always_ff @(posedge clk) begin
    if (rst || l || state_nx == IDLE) rcnt <= '0;
    else if (rpt_run) rcnt <= rpt ? '0 : rcnt + 1'b1;
  end
  assign rpt_pulse = rpt && !rst;
`else
  assign rpt_pulse = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: N_KEYS independent debounced keys with press/release/long events; KEY_AUTOREPEAT_EN adds auto-repeat.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] rpt_pulse
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .rpt_pulse    (rpt_pulse[i])
    );
  end
endmodule
